// File: rtl/mulinc_arbiter_if.sv
// Requester fabric <-> arbiter bundle: per-requester request lanes plus one response channel.
// No storage or latency of its own; it only groups the wires.
// Request lanes use valid/ready per requester; the response uses a single valid/ready pair.
interface mulinc_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_op;
  logic [2*NREQ-1:0] req_a;
  logic [2*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_c;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_op;
  logic [1:0]        rsp_data;

  // Fabric side: presents requests, consumes responses.
  modport master (
    output req_valid, req_op, req_a, req_b, req_c, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_op, rsp_data
  );

  // Arbiter side: grants requests, produces responses.
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_c, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_op, rsp_data
  );
endinterface

// File: rtl/mulinc_arbiter.sv
// Round-robin arbiter sharing one 2-bit mul/inc unit among NREQ requesters.
// Latency: grant in cycle T, registered response valid in cycle T+2; one op per 3 cycles peak.
// Backpressure: response held stable until rsp_ready; no grants are issued until it is taken.
module mulinc_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  mulinc_arbiter_if.slave bus,
  output logic            busy,
  output logic [CNTW-1:0] ops_done
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_RESP = 2'd2} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDW-1:0]    r_ptr;
  logic [CNTW-1:0]   r_cnt;
  logic [IDW-1:0]    r_g;
  logic              r_op;
  logic [1:0]        r_a;
  logic [1:0]        r_b;
  logic              r_c;
  logic              r_rsp_vld;
  logic [IDW-1:0]    r_rsp_id;
  logic              r_rsp_op;
  logic [1:0]        r_rsp_dat;

  logic [2*NREQ-1:0] w_vv;
  logic [NREQ-1:0]   w_rot;
  logic              w_any;
  logic [IDW-1:0]    w_gnt;
  logic [IDW:0]      w_sum;
  logic [NREQ-1:0]   w_rdy;
  logic [1:0]        w_mul;
  logic [1:0]        w_inc;
  logic [1:0]        w_res;

  // Rotate valids so bit 0 is the pointer position; the first set bit is the winner.
  always_comb begin
    w_vv  = {bus.req_valid, bus.req_valid};
    w_rot = NREQ'(w_vv >> r_ptr);
    w_any = 1'b0;
    w_gnt = '0;
    w_sum = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && w_rot[k]) begin
        w_any = 1'b1;
        w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
        if (w_sum >= (IDW+1)'(NREQ)) begin
          w_sum = w_sum - (IDW+1)'(NREQ);
        end
        w_gnt = w_sum[IDW-1:0];
      end
    end
  end

  // Grant is combinational and only offered while idle.
  always_comb begin
    w_rdy = '0;
    if (r_state == S_IDLE && w_any) begin
      w_rdy = NREQ'(1) << w_gnt;
    end
  end

  // Shared unit: a*b mod 4 and b+c mod 4 on the captured operands.
  always_comb begin
    w_mul = {(r_a[1] & r_b[0]) ^ (r_a[0] & r_b[1]), r_a[0] & r_b[0]};
    w_inc = {r_b[1] ^ (r_b[0] & r_c), r_b[0] ^ r_c};
    w_res = r_op ? w_inc : w_mul;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: a grant always transfers since the winner's valid is high by construction.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, response register, pointer and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_g       <= '0;
      r_op      <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_rsp_id  <= '0;
      r_rsp_op  <= 1'b0;
      r_rsp_dat <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_g  <= w_gnt;
            r_op <= 1'(bus.req_op >> w_gnt);
            r_a  <= 2'(bus.req_a >> {w_gnt, 1'b0});
            r_b  <= 2'(bus.req_b >> {w_gnt, 1'b0});
            r_c  <= 1'(bus.req_c >> w_gnt);
          end
        end
        S_EXEC: begin
          r_rsp_vld <= 1'b1;
          r_rsp_id  <= r_g;
          r_rsp_op  <= r_op;
          r_rsp_dat <= w_res;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_vld <= 1'b0;
            // Pointer moves past the served requester only once its response is taken.
            r_ptr     <= (r_g == IDW'(NREQ-1)) ? '0 : r_g + 1'b1;
            r_cnt     <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = w_rdy;
  assign bus.rsp_valid = r_rsp_vld;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_op    = r_rsp_op;
  assign bus.rsp_data  = r_rsp_dat;
  assign busy          = (r_state != S_IDLE);
  assign ops_done      = r_cnt;

endmodule
